// File: rtl/axi_mem_endpoint.sv
// AXI4 memory slave endpoint: one write burst and one read burst served concurrently from a local word array.
// Optional macro AXI_MEM_SLVERR_EN: out-of-range beats return SLVERR instead of wrapping modulo MEM_DEPTH.

package axi_mem_pkg;
  localparam int AXI_ADDR_W = 16;
  localparam int AXI_DATA_W = 8;
  localparam int AXI_IDW_W  = 5;
  localparam int AXI_IDR_W  = 5;

  typedef struct packed {
    logic [AXI_IDW_W-1:0]    aw_id;
    logic [AXI_ADDR_W-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_valid;
    logic [AXI_DATA_W-1:0]   w_data;
    logic [AXI_DATA_W/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    b_ready;
    logic [AXI_IDR_W-1:0]    ar_id;
    logic [AXI_ADDR_W-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_valid;
    logic                    r_ready;
  } axi_mosi_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_IDW_W-1:0]  b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_IDR_W-1:0]  r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
  } axi_miso_t;
endpackage

module axi_mem_endpoint
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int ID_W_WIDTH = AXI_IDW_W,
  parameter int ID_R_WIDTH = AXI_IDR_W,
  parameter int MEM_DEPTH  = 256
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  input  axi_mosi_t s_axi_i,
  output axi_miso_t s_axi_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int IW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic {R_IDLE, R_DATA} rState_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wState_t               r_wState;
  logic                  r_awReady, r_wReady, r_bValid, r_wErr;
  logic [1:0]            r_bResp, r_wBurst;
  logic [ID_W_WIDTH-1:0] r_bId;
  logic [IW-1:0]         r_wIdx;
  logic [7:0]            r_wLen, r_wCnt;

  rState_t               r_rState;
  logic                  r_arReady, r_rValid, r_rLast;
  logic [1:0]            r_rResp, r_rBurst;
  logic [ID_R_WIDTH-1:0] r_rId;
  logic [IW-1:0]         r_rIdx;
  logic [7:0]            r_rLen, r_rCnt;
  logic [DATA_WIDTH-1:0] r_rData;

  logic [IW-1:0] w_awIdx, w_arIdx, w_wNextIdx, w_rNextIdx;
  logic          w_wOob, w_arOob, w_rNextOob, w_wLastBeat, w_wBeatErr, w_memWe;
  logic          w_unused;

  // Indices stay un-wrapped one bit wider than the address so the out-of-range check can see them.
  assign w_awIdx    = {1'b0, s_axi_i.aw_addr} >> SHIFT;
  assign w_arIdx    = {1'b0, s_axi_i.ar_addr} >> SHIFT;
  assign w_wNextIdx = (r_wBurst == 2'b00) ? r_wIdx : r_wIdx + 1'b1;
  assign w_rNextIdx = (r_rBurst == 2'b00) ? r_rIdx : r_rIdx + 1'b1;

`ifdef AXI_MEM_SLVERR_EN
  assign w_wOob     = (r_wIdx >= IW'(MEM_DEPTH));
  assign w_arOob    = (w_arIdx >= IW'(MEM_DEPTH));
  assign w_rNextOob = (w_rNextIdx >= IW'(MEM_DEPTH));
`else
  assign w_wOob     = 1'b0;
  assign w_arOob    = 1'b0;
  assign w_rNextOob = 1'b0;
`endif

  assign w_wLastBeat = (r_wCnt == r_wLen);
  assign w_wBeatErr  = (s_axi_i.w_last != w_wLastBeat) | w_wOob;
  assign w_memWe     = (r_wState == W_DATA) & s_axi_i.w_valid & ~w_wOob;

  assign w_unused = ^{s_axi_i.aw_size, s_axi_i.w_strb, s_axi_i.ar_size,
                      r_wIdx[IW-1:IDX_W], r_rIdx[IW-1:IDX_W], w_arIdx[IW-1:IDX_W]};

  always_ff @(posedge ACLK) begin
    if (w_memWe) r_mem[r_wIdx[IDX_W-1:0]] <= s_axi_i.w_data;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wState  <= W_IDLE;
      r_awReady <= 1'b1;
      r_wReady  <= 1'b0;
      r_bValid  <= 1'b0;
      r_bResp   <= 2'b00;
      r_bId     <= '0;
      r_wIdx    <= '0;
      r_wLen    <= '0;
      r_wBurst  <= 2'b00;
      r_wCnt    <= '0;
      r_wErr    <= 1'b0;
    end else begin
      case (r_wState)
        W_IDLE: if (s_axi_i.aw_valid) begin
          r_bId     <= s_axi_i.aw_id;
          r_wIdx    <= w_awIdx;
          r_wLen    <= s_axi_i.aw_len;
          r_wBurst  <= s_axi_i.aw_burst;
          r_wCnt    <= '0;
          r_wErr    <= 1'b0;
          r_awReady <= 1'b0;
          r_wReady  <= 1'b1;
          r_wState  <= W_DATA;
        end
        W_DATA: if (s_axi_i.w_valid) begin
          if (w_wLastBeat) begin
            r_wReady <= 1'b0;
            r_bValid <= 1'b1;
            r_bResp  <= (r_wErr | w_wBeatErr) ? 2'b10 : 2'b00;
            r_wState <= W_RESP;
          end else begin
            r_wCnt <= r_wCnt + 8'd1;
            r_wIdx <= w_wNextIdx;
            r_wErr <= r_wErr | w_wBeatErr;
          end
        end
        W_RESP: if (s_axi_i.b_ready) begin
          r_bValid  <= 1'b0;
          r_awReady <= 1'b1;
          r_wState  <= W_IDLE;
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  // Read data is registered at the handshake edge, so it is read-first and holds steady through stalls.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rState  <= R_IDLE;
      r_arReady <= 1'b1;
      r_rValid  <= 1'b0;
      r_rLast   <= 1'b0;
      r_rResp   <= 2'b00;
      r_rId     <= '0;
      r_rIdx    <= '0;
      r_rLen    <= '0;
      r_rBurst  <= 2'b00;
      r_rCnt    <= '0;
      r_rData   <= '0;
    end else begin
      case (r_rState)
        R_IDLE: if (s_axi_i.ar_valid) begin
          r_rId     <= s_axi_i.ar_id;
          r_rIdx    <= w_arIdx;
          r_rLen    <= s_axi_i.ar_len;
          r_rBurst  <= s_axi_i.ar_burst;
          r_rCnt    <= '0;
          r_rLast   <= (s_axi_i.ar_len == 8'd0);
          r_rData   <= w_arOob ? '0 : r_mem[w_arIdx[IDX_W-1:0]];
          r_rResp   <= w_arOob ? 2'b10 : 2'b00;
          r_arReady <= 1'b0;
          r_rValid  <= 1'b1;
          r_rState  <= R_DATA;
        end
        R_DATA: if (s_axi_i.r_ready) begin
          if (r_rLast) begin
            r_rValid  <= 1'b0;
            r_rLast   <= 1'b0;
            r_arReady <= 1'b1;
            r_rState  <= R_IDLE;
          end else begin
            r_rCnt  <= r_rCnt + 8'd1;
            r_rIdx  <= w_rNextIdx;
            r_rLast <= ((r_rCnt + 8'd1) == r_rLen);
            r_rData <= w_rNextOob ? '0 : r_mem[w_rNextIdx[IDX_W-1:0]];
            r_rResp <= w_rNextOob ? 2'b10 : 2'b00;
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

  assign s_axi_o = '{aw_ready: r_awReady, w_ready: r_wReady, b_id: r_bId, b_resp: r_bResp,
                     b_valid: r_bValid, ar_ready: r_arReady, r_id: r_rId, r_data: r_rData,
                     r_resp: r_rResp, r_last: r_rLast, r_valid: r_rValid};

endmodule

// File: tb/tb_axi_mem_endpoint.sv
// Directed testbench for axi_mem_endpoint; the out-of-range read case is built only with AXI_MEM_SLVERR_EN.

module tb_axi_mem_endpoint;
  import axi_mem_pkg::*;

  logic      ACLK = 1'b0;
  logic      ARESETn = 1'b1;
  axi_mosi_t mosi;
  axi_miso_t miso;
  int        errors = 0;
  int        checks = 0;

  axi_mem_endpoint dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi_i (mosi),
    .s_axi_o (miso)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive tasks start and end on a falling edge; outputs are registered so they are stable there.
  task automatic awSend(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [4:0] id);
    int n = 0;
    mosi.aw_addr = addr; mosi.aw_len = len; mosi.aw_burst = burst; mosi.aw_id = id; mosi.aw_valid = 1'b1;
    while (!miso.aw_ready && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) begin checks++; errors++; $display("[TB] FAIL aw_timeout: awready=%0b want 1", miso.aw_ready); end
    @(negedge ACLK);
    mosi.aw_valid = 1'b0;
  endtask

  task automatic arSend(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [4:0] id);
    int n = 0;
    mosi.ar_addr = addr; mosi.ar_len = len; mosi.ar_burst = burst; mosi.ar_id = id; mosi.ar_valid = 1'b1;
    while (!miso.ar_ready && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) begin checks++; errors++; $display("[TB] FAIL ar_timeout: arready=%0b want 1", miso.ar_ready); end
    @(negedge ACLK);
    mosi.ar_valid = 1'b0;
  endtask

  task automatic wSend(input logic [7:0] data, input logic last);
    int n = 0;
    mosi.w_data = data; mosi.w_last = last; mosi.w_valid = 1'b1;
    while (!miso.w_ready && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) begin checks++; errors++; $display("[TB] FAIL w_timeout: wready=%0b want 1", miso.w_ready); end
    @(negedge ACLK);
    mosi.w_valid = 1'b0;
  endtask

  task automatic bTake();
    int n = 0;
    mosi.b_ready = 1'b1;
    while (!miso.b_valid && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) begin checks++; errors++; $display("[TB] FAIL b_timeout: bvalid=%0b want 1", miso.b_valid); end
    @(negedge ACLK);
    mosi.b_ready = 1'b0;
  endtask

  task automatic rTake();
    int n = 0;
    mosi.r_ready = 1'b1;
    while (!miso.r_valid && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) begin checks++; errors++; $display("[TB] FAIL r_timeout: rvalid=%0b want 1", miso.r_valid); end
    @(negedge ACLK);
    mosi.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++; if (miso.aw_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_awready: got %0b want 1", miso.aw_ready); end
    checks++; if (miso.ar_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_arready: got %0b want 1", miso.ar_ready); end
    checks++; if (miso.w_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_wready: got %0b want 0", miso.w_ready); end
    checks++; if (miso.b_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_bvalid: got %0b want 0", miso.b_valid); end
    checks++; if (miso.r_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %0b want 0", miso.r_valid); end
    checks++; if (miso.b_resp !== 2'b00) begin errors++; $display("[TB] FAIL rst_bresp: got %b want 00", miso.b_resp); end
    checks++; if (miso.r_resp !== 2'b00) begin errors++; $display("[TB] FAIL rst_rresp: got %b want 00", miso.r_resp); end
    checks++; if (miso.r_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_rlast: got %0b want 0", miso.r_last); end
    ARESETn = 1'b1;
  endtask

  task automatic test_single();
    awSend(16'h0010, 8'd0, 2'b01, 5'd3);
    wSend(8'hA5, 1'b1);
    checks++; if (miso.b_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_bvalid: got %0b want 1", miso.b_valid); end
    checks++; if (miso.b_id !== 5'd3) begin errors++; $display("[TB] FAIL single_bid: got %0d want 3", miso.b_id); end
    checks++; if (miso.b_resp !== 2'b00) begin errors++; $display("[TB] FAIL single_bresp: got %b want 00", miso.b_resp); end
    checks++; if (miso.aw_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_awready_busy: got %0b want 0", miso.aw_ready); end
    bTake();
    arSend(16'h0010, 8'd0, 2'b01, 5'd7);
    checks++; if (miso.r_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_rvalid: got %0b want 1", miso.r_valid); end
    checks++; if (miso.r_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_rdata: got %h want a5", miso.r_data); end
    checks++; if (miso.r_id !== 5'd7) begin errors++; $display("[TB] FAIL single_rid: got %0d want 7", miso.r_id); end
    checks++; if (miso.r_last !== 1'b1) begin errors++; $display("[TB] FAIL single_rlast: got %0b want 1", miso.r_last); end
    checks++; if (miso.r_resp !== 2'b00) begin errors++; $display("[TB] FAIL single_rresp: got %b want 00", miso.r_resp); end
    rTake();
    checks++; if (miso.r_valid !== 1'b0 || miso.ar_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL single_rdone: rvalid=%0b arready=%0b want 0/1", miso.r_valid, miso.ar_ready);
    end
  endtask

  task automatic test_incr();
    int beat = 0;
    int cyc = 0;
    awSend(16'h0020, 8'd3, 2'b01, 5'd1);
    for (int i = 0; i < 4; i++) wSend(8'(i + 1), i == 3);
    checks++; if (miso.b_resp !== 2'b00) begin errors++; $display("[TB] FAIL incr_bresp: got %b want 00", miso.b_resp); end
    bTake();
    arSend(16'h0020, 8'd3, 2'b01, 5'd2);
    while (beat < 4 && cyc < 40) begin
      mosi.r_ready = (cyc % 2 == 1);
      checks++;
      if (miso.r_valid !== 1'b1 || miso.r_data !== 8'(beat + 1) || miso.r_last !== (beat == 3)) begin
        errors++;
        $display("[TB] FAIL incr_beat%0d: valid=%0b data=%0d last=%0b want 1/%0d/%0b",
                 beat, miso.r_valid, miso.r_data, miso.r_last, beat + 1, beat == 3);
      end
      if (mosi.r_ready) beat++;
      @(negedge ACLK);
      cyc++;
    end
    mosi.r_ready = 1'b0;
    checks++; if (beat != 4 || miso.r_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL incr_end: beats=%0d rvalid=%0b want 4/0", beat, miso.r_valid);
    end
  endtask

  task automatic test_fixed();
    awSend(16'h0031, 8'd0, 2'b01, 5'd0);
    wSend(8'h5C, 1'b1);
    bTake();
    awSend(16'h0030, 8'd2, 2'b00, 5'd1);
    wSend(8'd9, 1'b0);
    wSend(8'd8, 1'b0);
    wSend(8'd7, 1'b1);
    checks++; if (miso.b_resp !== 2'b00) begin errors++; $display("[TB] FAIL fixed_bresp: got %b want 00", miso.b_resp); end
    bTake();
    arSend(16'h0030, 8'd1, 2'b01, 5'd4);
    checks++; if (miso.r_data !== 8'd7 || miso.r_last !== 1'b0) begin
      errors++; $display("[TB] FAIL fixed_word30: data=%0d last=%0b want 7/0", miso.r_data, miso.r_last);
    end
    rTake();
    checks++; if (miso.r_data !== 8'h5C || miso.r_last !== 1'b1) begin
      errors++; $display("[TB] FAIL fixed_word31: data=%h last=%0b want 5c/1", miso.r_data, miso.r_last);
    end
    rTake();
  endtask

  task automatic test_wlast_err();
    awSend(16'h0050, 8'd1, 2'b01, 5'd9);
    wSend(8'hAA, 1'b1);
    wSend(8'hBB, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (miso.b_valid !== 1'b1 || miso.b_id !== 5'd9 || miso.b_resp !== 2'b10 || miso.aw_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wlast_hold%0d: bvalid=%0b bid=%0d bresp=%b awready=%0b want 1/9/10/0",
                 i, miso.b_valid, miso.b_id, miso.b_resp, miso.aw_ready);
      end
      @(negedge ACLK);
    end
    bTake();
    checks++; if (miso.aw_ready !== 1'b1 || miso.b_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wlast_release: awready=%0b bvalid=%0b want 1/0", miso.aw_ready, miso.b_valid);
    end
  endtask

  task automatic test_collision();
    awSend(16'h0040, 8'd0, 2'b01, 5'd0);
    wSend(8'h11, 1'b1);
    bTake();
    mosi.aw_addr = 16'h0040; mosi.aw_len = 8'd0; mosi.aw_burst = 2'b01; mosi.aw_id = 5'd4; mosi.aw_valid = 1'b1;
    mosi.ar_addr = 16'h0040; mosi.ar_len = 8'd0; mosi.ar_burst = 2'b01; mosi.ar_id = 5'd5; mosi.ar_valid = 1'b1;
    @(negedge ACLK);
    mosi.aw_valid = 1'b0; mosi.ar_valid = 1'b0;
    checks++; if (miso.w_ready !== 1'b1 || miso.r_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL coll_both_accepted: wready=%0b rvalid=%0b want 1/1", miso.w_ready, miso.r_valid);
    end
    mosi.w_data = 8'h22; mosi.w_last = 1'b1; mosi.w_valid = 1'b1; mosi.r_ready = 1'b1;
    checks++; if (miso.r_data !== 8'h11 || miso.r_id !== 5'd5) begin
      errors++; $display("[TB] FAIL coll_readfirst: data=%h id=%0d want 11/5", miso.r_data, miso.r_id);
    end
    @(negedge ACLK);
    mosi.w_valid = 1'b0; mosi.r_ready = 1'b0;
    checks++; if (miso.b_valid !== 1'b1 || miso.r_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL coll_done: bvalid=%0b rvalid=%0b want 1/0", miso.b_valid, miso.r_valid);
    end
    bTake();
    arSend(16'h0040, 8'd0, 2'b01, 5'd6);
    checks++; if (miso.r_data !== 8'h22) begin errors++; $display("[TB] FAIL coll_later: got %h want 22", miso.r_data); end
    rTake();
  endtask

  task automatic test_reset_mid_read();
    awSend(16'h0060, 8'd7, 2'b01, 5'd2);
    for (int i = 0; i < 8; i++) wSend(8'(8'h30 + i), i == 7);
    bTake();
    arSend(16'h0060, 8'd7, 2'b01, 5'd2);
    rTake();
    rTake();
    checks++; if (miso.r_data !== 8'h32 || miso.r_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midrd_beat2: data=%h rvalid=%0b want 32/1", miso.r_data, miso.r_valid);
    end
    ARESETn = 1'b0;
    #1;
    checks++; if (miso.r_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrd_rvalid: got %0b want 0", miso.r_valid); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    checks++; if (miso.ar_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrd_arready: got %0b want 1", miso.ar_ready); end
    arSend(16'h0062, 8'd1, 2'b01, 5'd8);
    checks++; if (miso.r_data !== 8'h32 || miso.r_last !== 1'b0 || miso.r_id !== 5'd8) begin
      errors++; $display("[TB] FAIL midrd_next0: data=%h last=%0b id=%0d want 32/0/8", miso.r_data, miso.r_last, miso.r_id);
    end
    rTake();
    checks++; if (miso.r_data !== 8'h33 || miso.r_last !== 1'b1) begin
      errors++; $display("[TB] FAIL midrd_next1: data=%h last=%0b want 33/1", miso.r_data, miso.r_last);
    end
    rTake();
  endtask

`ifdef AXI_MEM_SLVERR_EN
  task automatic test_slverr();
    arSend(16'h0100, 8'd0, 2'b01, 5'd6);
    checks++; if (miso.r_resp !== 2'b10 || miso.r_data !== 8'h00) begin
      errors++; $display("[TB] FAIL slverr_read: resp=%b data=%h want 10/00", miso.r_resp, miso.r_data);
    end
    rTake();
  endtask
`endif

  initial begin
    mosi = '0;
    mosi.w_strb = 1'b1;
    test_reset();
    test_single();
    test_incr();
    test_fixed();
    test_wlast_err();
    test_collision();
    test_reset_mid_read();
`ifdef AXI_MEM_SLVERR_EN
    test_slverr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
